tl_ul_scratchpad: RTL and testbench
===================================

Name: tl_ul_scratchpad

Overview:
- TL-UL slave memory that sits directly downstream of the peripheral-bus fragmenter. It consumes single-beat, 64-bit requests (size ≤ 3) on a 26-bit address space.
- Backed by a flop array of 2^DEPTH_LOG2 64-bit words.
- Returns AccessAck/AccessAckData through a credit-managed response queue, so D-channel backpressure never drops or reorders responses.

Parameters:
- BASE_ADDR, 26'h3000000, base byte address; must be aligned to the region size 8<<DEPTH_LOG2.
- DEPTH_LOG2, 6, log2 of word count (64 words = 512 B).
- SOURCE_W, 9, A/D source field width.
- RESP_DEPTH, 2, response queue entries; must be ≥ 1; ≥ 2 gives full throughput.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- in_a_ready  out  1  A-channel ready.
- in_a_valid  in  1  A-channel valid.
- in_a_bits_opcode  in  3  TL A opcode.
- in_a_bits_param  in  3  ignored.
- in_a_bits_size  in  2  log2 bytes, 0..3.
- in_a_bits_source  in  SOURCE_W  request tag.
- in_a_bits_address  in  26  byte address.
- in_a_bits_mask  in  8  byte lanes.
- in_a_bits_data  in  64  write data.
- in_a_bits_corrupt  in  1  when 1 on a Put, the write is suppressed.
- in_d_ready  in  1  D-channel ready.
- in_d_valid  out  1  D-channel valid.
- in_d_bits_opcode  out  3  0 = AccessAck, 1 = AccessAckData, 2 = HintAck.
- in_d_bits_param  out  2  always 0.
- in_d_bits_size  out  2  echo of the request size.
- in_d_bits_source  out  SOURCE_W  echo of the request source.
- in_d_bits_sink  out  1  always 0.
- in_d_bits_denied  out  1  request rejected.
- in_d_bits_data  out  64  read data; 0 when not a successful Get.
- in_d_bits_corrupt  out  1  equals denied on AccessAckData, else 0.
- prot_err  out  1  sticky protocol error; present only with TL_SCRATCH_PROTCHK_EN.

Behaviour:
- Reset (async, active-high):
  - queue empty, in_d_valid = 0, credits = RESP_DEPTH, in_a_ready = 1 after release, prot_err = 0.
  - All storage words cleared to 0.
  - Reset mid-transaction discards all queued responses; the master is reset by the same signal.
- Credits:
  - Counter 0..RESP_DEPTH.
  - Decrements on A fire, increments on D fire; both in the same cycle → unchanged.
  - in_a_ready = (credits != 0), registered-only; no combinational path from in_d_ready.
- Decode:
  - hit = address[25:DEPTH_LOG2+3] == BASE_ADDR[25:DEPTH_LOG2+3].
  - word index = address[DEPTH_LOG2+2:3].
- Request cycle N (A fire):
  - Get(4): hit → response data = storage[idx], full word, all lanes; miss → denied = 1, data = 0. Opcode AccessAckData.
  - PutFull(0) / PutPartial(1): hit and !corrupt → bytes with mask[i] = 1 are written at the end of cycle N; miss → denied = 1, no write. Opcode AccessAck.
  - Arithmetic(2) / Logical(3): denied = 1, opcode AccessAckData, data = 0, no write.
  - Hint(5): HintAck, denied = 0, no state change.
  - Opcodes 6 and 7: denied = 1, opcode AccessAck.
- Response:
  - Pushed into the queue at the end of cycle N; in_d_valid can assert in cycle N+1 (latency 1).
  - Responses are in-order FIFO.
  - in_d_bits stay stable while in_d_valid && !in_d_ready.
- Hazards:
  - A Put in cycle N followed by a Get to the same word in cycle N+1 returns the new data.
  - A Get and a Put are never accepted in the same cycle (one request per cycle).
- Full/empty:
  - With credits = 0, in_a_ready = 0 until a D fire.
  - The queue can never overflow, because credits bound its occupancy.
  - With the queue empty, in_d_valid = 0.
- Throughput: RESP_DEPTH = 2 with in_d_ready held high sustains one request per cycle.

Optional Feature:
- Macro: TL_SCRATCH_PROTCHK_EN.
- Defined:
  - Each accepted request is checked: address aligned to 1<<size; mask equals the lane mask for size/address[2:0]; size ≤ 3.
  - A violation forces denied = 1, suppresses any write and sets prot_err, which stays set until reset.
  - The prot_err port exists.
- Undefined: no checks, no prot_err port; misaligned requests execute using the mask as given.

Test Plan:
- Reset then idle → in_a_ready = 1, in_d_valid = 0; a Get to BASE_ADDR+0x10 returns data 0, denied 0, opcode 1.
- PutFull size 3 at BASE_ADDR+0x8, data 64'h0123456789ABCDEF, source 9'h155; Get next cycle → AccessAck with source 9'h155, then AccessAckData with data 64'h0123456789ABCDEF, in order.
- PutPartial mask 8'h0F data 64'hFFFFFFFF_AAAAAAAA over prior 64'h0123456789ABCDEF → readback 64'h01234567_AAAAAAAA.
- Get at BASE_ADDR+0x200 (out of range) → denied 1, corrupt 1, data 0, size echoed; Put to the same address leaves storage unchanged.
- in_d_ready = 0, 3 Gets offered → 2 accepted, then in_a_ready = 0; release in_d_ready → responses drain in order, third request is accepted in the cycle after the first D fire.
- With TL_SCRATCH_PROTCHK_EN: Put size 2 at address offset 0x2 → denied 1, no write, prot_err = 1 held until reset.

Source files
------------

// File: rtl/tl_ul_scratchpad.sv
// TL-UL single-beat scratchpad RAM with a credit-managed, in-order response queue.
// Optional protocol checking and the prot_err port are enabled by TL_SCRATCH_PROTCHK_EN.
module tl_ul_scratchpad #(
  parameter logic [25:0] BASE_ADDR  = 26'h3000000,
  parameter int          DEPTH_LOG2 = 6,
  parameter int          SOURCE_W   = 9,
  parameter int          RESP_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic                in_a_ready,
  input  logic                in_a_valid,
  input  logic [2:0]          in_a_bits_opcode,
  input  logic [2:0]          in_a_bits_param,
  input  logic [1:0]          in_a_bits_size,
  input  logic [SOURCE_W-1:0] in_a_bits_source,
  input  logic [25:0]         in_a_bits_address,
  input  logic [7:0]          in_a_bits_mask,
  input  logic [63:0]         in_a_bits_data,
  input  logic                in_a_bits_corrupt,
  input  logic                in_d_ready,
  output logic                in_d_valid,
  output logic [2:0]          in_d_bits_opcode,
  output logic [1:0]          in_d_bits_param,
  output logic [1:0]          in_d_bits_size,
  output logic [SOURCE_W-1:0] in_d_bits_source,
  output logic                in_d_bits_sink,
  output logic                in_d_bits_denied,
  output logic [63:0]         in_d_bits_data,
  output logic                in_d_bits_corrupt
`ifdef TL_SCRATCH_PROTCHK_EN
  ,
  output logic                prot_err
`endif
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam int QW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(RESP_DEPTH);
  localparam logic [QW-1:0] PTR_LAST = QW'(RESP_DEPTH - 1);

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITHMETIC  = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4,
    A_HINT        = 3'd5
  } a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } d_op_e;

  typedef struct packed {
    d_op_e               opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [63:0]         data;
    logic                corrupt;
  } resp_t;

  logic [63:0]           mem [WORDS];
  resp_t                 queue [RESP_DEPTH];
  resp_t                 resp_next;
  resp_t                 head;
  logic [QW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         credits;
  logic                  a_fire, d_fire;
  logic                  hit, viol, do_write;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_bits;

  assign unused_bits = ^{in_a_bits_param, in_a_bits_address[2:0]};

  assign in_a_ready = (credits != '0);
  assign in_d_valid = (credits != CRED_MAX);
  assign a_fire     = in_a_valid && in_a_ready;
  assign d_fire     = in_d_valid && in_d_ready;

  assign hit = (in_a_bits_address[25:DEPTH_LOG2+3] == BASE_ADDR[25:DEPTH_LOG2+3]);
  assign idx = in_a_bits_address[DEPTH_LOG2+2:3];

`ifdef TL_SCRATCH_PROTCHK_EN
  logic [7:0] size_mask;
  logic [8:0] lane_span;
  logic [7:0] lane_mask;

  // Lane mask for size/offset; a 9-bit span keeps the 8-byte case from overflowing.
  assign size_mask = (8'd1 << in_a_bits_size) - 8'd1;
  assign lane_span = (9'd1 << (4'd1 << in_a_bits_size)) - 9'd1;
  assign lane_mask = lane_span[7:0] << in_a_bits_address[2:0];
  assign viol      = (|(in_a_bits_address[2:0] & size_mask[2:0])) ||
                     (in_a_bits_mask != lane_mask);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prot_err <= 1'b0;
    else if (a_fire && viol) prot_err <= 1'b1;
  end
`else
  assign viol = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    resp_next        = '0;
    resp_next.size   = in_a_bits_size;
    resp_next.source = in_a_bits_source;
    do_write         = 1'b0;
    case (in_a_bits_opcode)
      A_GET: begin
        resp_next.opcode  = D_ACCESS_ACK_DATA;
        resp_next.denied  = !hit || viol;
        resp_next.corrupt = resp_next.denied;
        resp_next.data    = resp_next.denied ? 64'd0 : mem[idx];
      end
      A_PUT_FULL, A_PUT_PARTIAL: begin
        resp_next.opcode = D_ACCESS_ACK;
        resp_next.denied = !hit || viol;
        do_write         = a_fire && hit && !viol && !in_a_bits_corrupt;
      end
      A_ARITHMETIC, A_LOGICAL: begin
        resp_next.opcode  = D_ACCESS_ACK_DATA;
        resp_next.denied  = 1'b1;
        resp_next.corrupt = 1'b1;
      end
      A_HINT: begin
        resp_next.opcode = D_HINT_ACK;
        resp_next.denied = viol;
      end
      default: begin
        resp_next.opcode = D_ACCESS_ACK;
        resp_next.denied = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credits <= CRED_MAX;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      case ({a_fire, d_fire})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      if (a_fire) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (d_fire) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  // NOTE: storage must read as zero after reset, so it is cleared; the queue payload
  // is never visible while empty and is left without reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 8; b++)
        if (in_a_bits_mask[b]) mem[idx][8*b +: 8] <= in_a_bits_data[8*b +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (a_fire) queue[wr_ptr] <= resp_next;
  end

  assign head              = queue[rd_ptr];
  assign in_d_bits_opcode  = head.opcode;
  assign in_d_bits_param   = 2'd0;
  assign in_d_bits_size    = head.size;
  assign in_d_bits_source  = head.source;
  assign in_d_bits_sink    = 1'b0;
  assign in_d_bits_denied  = head.denied;
  assign in_d_bits_data    = head.data;
  assign in_d_bits_corrupt = head.corrupt;

endmodule

// File: tb/tb_tl_ul_scratchpad.sv
// Self-checking bench for tl_ul_scratchpad: directed scenarios plus randomized traffic
// scored against a byte-array memory model and an in-order expected-response queue.
module tb_tl_ul_scratchpad;

  localparam logic [25:0] BASE       = 26'h3000000;
  localparam int          WORDS      = 64;
  localparam int          RESP_DEPTH = 2;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [8:0]  source;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } rsp_t;

  logic        clock, reset;
  logic        in_a_ready, in_a_valid;
  logic [2:0]  in_a_bits_opcode, in_a_bits_param;
  logic [1:0]  in_a_bits_size;
  logic [8:0]  in_a_bits_source;
  logic [25:0] in_a_bits_address;
  logic [7:0]  in_a_bits_mask;
  logic [63:0] in_a_bits_data;
  logic        in_a_bits_corrupt;
  logic        in_d_ready, in_d_valid;
  logic [2:0]  in_d_bits_opcode;
  logic [1:0]  in_d_bits_param;
  logic [1:0]  in_d_bits_size;
  logic [8:0]  in_d_bits_source;
  logic        in_d_bits_sink, in_d_bits_denied;
  logic [63:0] in_d_bits_data;
  logic        in_d_bits_corrupt;
`ifdef TL_SCRATCH_PROTCHK_EN
  logic        prot_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [63:0] model_mem [WORDS];
  rsp_t        exp_q[$];
  rsp_t        popped[$];

  tl_ul_scratchpad dut (
    .clock(clock), .reset(reset),
    .in_a_ready(in_a_ready), .in_a_valid(in_a_valid),
    .in_a_bits_opcode(in_a_bits_opcode), .in_a_bits_param(in_a_bits_param),
    .in_a_bits_size(in_a_bits_size), .in_a_bits_source(in_a_bits_source),
    .in_a_bits_address(in_a_bits_address), .in_a_bits_mask(in_a_bits_mask),
    .in_a_bits_data(in_a_bits_data), .in_a_bits_corrupt(in_a_bits_corrupt),
    .in_d_ready(in_d_ready), .in_d_valid(in_d_valid),
    .in_d_bits_opcode(in_d_bits_opcode), .in_d_bits_param(in_d_bits_param),
    .in_d_bits_size(in_d_bits_size), .in_d_bits_source(in_d_bits_source),
    .in_d_bits_sink(in_d_bits_sink), .in_d_bits_denied(in_d_bits_denied),
    .in_d_bits_data(in_d_bits_data), .in_d_bits_corrupt(in_d_bits_corrupt)
`ifdef TL_SCRATCH_PROTCHK_EN
    , .prot_err(prot_err)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic bit prot_viol(input logic [25:0] a, input logic [1:0] s, input logic [7:0] m);
`ifdef TL_SCRATCH_PROTCHK_EN
    int nbytes = 1 << s;
    int off    = int'(a) % 8;
    int lanes  = ((1 << nbytes) - 1) << off;
    logic [7:0] lane8 = lanes[7:0];
    return ((int'(a) % nbytes) != 0) || (m != lane8);
`else
    return (a == 26'h0) && (s == 2'd0) && (m == 8'h0) && 1'b0;
`endif
  endfunction

  task automatic model_clear();
    exp_q.delete();
    popped.delete();
    for (int i = 0; i < WORDS; i++) model_mem[i] = 64'd0;
  endtask

  // Behavioural model of one accepted request: decode by address range, then apply opcode rules.
  task automatic model_accept();
    rsp_t r;
    int   a, idx;
    bit   hit, v;
    a   = int'(in_a_bits_address);
    hit = (a >= int'(BASE)) && (a < int'(BASE) + 8 * WORDS);
    idx = hit ? (a - int'(BASE)) / 8 : 0;
    v   = prot_viol(in_a_bits_address, in_a_bits_size, in_a_bits_mask);
    r        = '0;
    r.size   = in_a_bits_size;
    r.source = in_a_bits_source;
    case (in_a_bits_opcode)
      3'd4: begin
        r.opcode = 3'd1; r.denied = !hit || v; r.corrupt = r.denied;
        if (!r.denied) r.data = model_mem[idx];
      end
      3'd0, 3'd1: begin
        r.opcode = 3'd0; r.denied = !hit || v;
        if (!r.denied && !in_a_bits_corrupt)
          for (int b = 0; b < 8; b++)
            if (in_a_bits_mask[b]) model_mem[idx][8*b +: 8] = in_a_bits_data[8*b +: 8];
      end
      3'd2, 3'd3: begin r.opcode = 3'd1; r.denied = 1'b1; r.corrupt = 1'b1; end
      3'd5:       begin r.opcode = 3'd2; r.denied = v; end
      default:    begin r.opcode = 3'd0; r.denied = 1'b1; end
    endcase
    exp_q.push_back(r);
  endtask

  // One clock: sample on the falling edge, score flow control and the D head, update the model.
  task automatic tick(output bit acc);
    rsp_t obs, ex;
    bit   exp_rdy, exp_vld, a_fire, d_fire;
    @(negedge clock);
    cyc++;
    exp_rdy = (exp_q.size() < RESP_DEPTH);
    exp_vld = (exp_q.size() != 0);
    vectors++;
    if (in_a_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL a_ready cyc=%0d got=%b exp=%b", cyc, in_a_ready, exp_rdy);
    end
    vectors++;
    if (in_d_valid !== exp_vld) begin
      miscompares++;
      $display("FAIL d_valid cyc=%0d got=%b exp=%b", cyc, in_d_valid, exp_vld);
    end
    obs = {in_d_bits_opcode, in_d_bits_size, in_d_bits_source, in_d_bits_denied,
           in_d_bits_data, in_d_bits_corrupt};
    if (exp_vld && in_d_valid === 1'b1) begin
      ex = exp_q[0];
      vectors++;
      if (obs !== ex || in_d_bits_param !== 2'd0 || in_d_bits_sink !== 1'b0) begin
        miscompares++;
        $display("FAIL d_resp cyc=%0d got op=%0d sz=%0d src=%h den=%b data=%h cor=%b prm=%0d snk=%b exp op=%0d sz=%0d src=%h den=%b data=%h cor=%b",
                 cyc, obs.opcode, obs.size, obs.source, obs.denied, obs.data, obs.corrupt,
                 in_d_bits_param, in_d_bits_sink,
                 ex.opcode, ex.size, ex.source, ex.denied, ex.data, ex.corrupt);
      end
    end
    d_fire = (in_d_valid === 1'b1) && in_d_ready;
    a_fire = in_a_valid && (in_a_ready === 1'b1);
    if (d_fire && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      popped.push_back(obs);
    end
    if (a_fire) model_accept();
    acc = a_fire;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [8:0] src,
                      input logic [25:0] addr, input logic [7:0] mask, input logic [63:0] data,
                      input logic corrupt);
    bit acc;
    int n;
    in_a_bits_opcode  = op;
    in_a_bits_size    = size;
    in_a_bits_source  = src;
    in_a_bits_address = addr;
    in_a_bits_mask    = mask;
    in_a_bits_data    = data;
    in_a_bits_corrupt = corrupt;
    in_a_valid        = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    in_a_valid = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL send_timeout addr=%h got=not_accepted exp=accepted", addr);
    end
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    in_d_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      tick(acc);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    in_a_valid = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    bit acc;
    in_a_bits_param = 3'd0;
    in_d_ready = 1'b0;
    apply_reset();
    vectors++;
    if (in_a_ready !== 1'b1 || in_d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b vld=%b exp rdy=1 vld=0", in_a_ready, in_d_valid);
    end
`ifdef TL_SCRATCH_PROTCHK_EN
    vectors++;
    if (prot_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_prot_err got=%b exp=0", prot_err);
    end
`endif
    repeat (3) tick(acc);
  endtask

  task automatic test_get_after_reset();
    popped.delete();
    in_d_ready = 1'b1;
    send(3'd4, 2'd3, 9'h011, BASE + 26'h10, 8'hFF, 64'd0, 1'b0);
    drain();
    vectors++;
    if (popped.size() != 1 || popped[0].data !== 64'd0 || popped[0].denied !== 1'b0 ||
        popped[0].opcode !== 3'd1) begin
      miscompares++;
      $display("FAIL get_after_reset got n=%0d exp n=1 data=0 den=0 op=1", popped.size());
    end
  endtask

  task automatic test_put_get();
    popped.delete();
    in_d_ready = 1'b1;
    send(3'd0, 2'd3, 9'h155, BASE + 26'h8, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
    send(3'd4, 2'd3, 9'h0AB, BASE + 26'h8, 8'hFF, 64'd0, 1'b0);
    drain();
    vectors++;
    if (popped.size() != 2) begin
      miscompares++;
      $display("FAIL put_get_count got=%0d exp=2", popped.size());
    end else begin
      vectors++;
      if (popped[0].opcode !== 3'd0 || popped[0].source !== 9'h155 || popped[0].denied !== 1'b0) begin
        miscompares++;
        $display("FAIL put_ack got op=%0d src=%h exp op=0 src=155", popped[0].opcode, popped[0].source);
      end
      vectors++;
      if (popped[1].opcode !== 3'd1 || popped[1].data !== 64'h0123456789ABCDEF) begin
        miscompares++;
        $display("FAIL get_data got op=%0d data=%h exp op=1 data=0123456789abcdef",
                 popped[1].opcode, popped[1].data);
      end
    end
  endtask

  task automatic test_partial();
    popped.delete();
    in_d_ready = 1'b1;
    send(3'd1, 2'd3, 9'h002, BASE + 26'h8, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 1'b0);
    send(3'd4, 2'd3, 9'h003, BASE + 26'h8, 8'hFF, 64'd0, 1'b0);
    drain();
    vectors++;
    if (popped.size() != 2 || popped[1].data !== 64'h01234567_AAAAAAAA) begin
      miscompares++;
      $display("FAIL partial_merge got n=%0d exp n=2 data=01234567aaaaaaaa", popped.size());
    end
  endtask

  task automatic test_out_of_range();
    popped.delete();
    in_d_ready = 1'b1;
    send(3'd4, 2'd3, 9'h0AA, BASE + 26'h200, 8'hFF, 64'd0, 1'b0);
    send(3'd0, 2'd3, 9'h0AB, BASE + 26'h200, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0);
    send(3'd4, 2'd3, 9'h0AC, BASE, 8'hFF, 64'd0, 1'b0);
    drain();
    vectors++;
    if (popped.size() != 3) begin
      miscompares++;
      $display("FAIL oor_count got=%0d exp=3", popped.size());
    end else begin
      vectors++;
      if (popped[0].denied !== 1'b1 || popped[0].corrupt !== 1'b1 || popped[0].data !== 64'd0 ||
          popped[0].size !== 2'd3) begin
        miscompares++;
        $display("FAIL oor_get got den=%b cor=%b data=%h sz=%0d exp den=1 cor=1 data=0 sz=3",
                 popped[0].denied, popped[0].corrupt, popped[0].data, popped[0].size);
      end
      vectors++;
      if (popped[1].denied !== 1'b1 || popped[2].data !== 64'd0) begin
        miscompares++;
        $display("FAIL oor_put got den=%b word0=%h exp den=1 word0=0", popped[1].denied, popped[2].data);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    popped.delete();
    in_d_ready = 1'b0;
    send(3'd4, 2'd3, 9'h001, BASE + 26'h8, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 2'd3, 9'h002, BASE + 26'h10, 8'hFF, 64'd0, 1'b0);
    in_a_bits_source  = 9'h003;
    in_a_bits_address = BASE + 26'h18;
    in_a_valid        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      vectors++;
      if (acc) begin
        miscompares++;
        $display("FAIL bp_stall got=accepted exp=stalled");
      end
    end
    in_d_ready = 1'b1;
    tick(acc);
    vectors++;
    if (acc || popped.size() != 1) begin
      miscompares++;
      $display("FAIL bp_release got acc=%b fired=%0d exp acc=0 fired=1", acc, popped.size());
    end
    tick(acc);
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL bp_reaccept got=stalled exp=accepted");
    end
    in_a_valid = 1'b0;
    drain();
    vectors++;
    if (popped.size() != 3 || popped[0].source !== 9'h001 || popped[1].source !== 9'h002 ||
        popped[2].source !== 9'h003 || popped[0].data !== 64'h01234567_AAAAAAAA) begin
      miscompares++;
      $display("FAIL bp_order got n=%0d exp n=3 sources 1,2,3", popped.size());
    end
  endtask

`ifdef TL_SCRATCH_PROTCHK_EN
  task automatic test_protchk();
    bit acc;
    popped.delete();
    in_d_ready = 1'b1;
    send(3'd0, 2'd2, 9'h010, BASE + 26'h2, 8'h3C, 64'h11223344_55667788, 1'b0);
    send(3'd4, 2'd3, 9'h011, BASE, 8'hFF, 64'd0, 1'b0);
    drain();
    repeat (3) tick(acc);
    vectors++;
    if (popped.size() != 2 || popped[0].denied !== 1'b1 || popped[1].data !== 64'd0 ||
        prot_err !== 1'b1) begin
      miscompares++;
      $display("FAIL protchk got n=%0d prot_err=%b exp n=2 den=1 data=0 prot_err=1",
               popped.size(), prot_err);
    end
  endtask
`endif

  task automatic test_random();
    bit acc;
    int sel;
    for (int i = 0; i < 800; i++) begin
      in_d_ready = ($urandom_range(3) != 0);
      in_a_valid = ($urandom_range(2) != 0);
      sel = $urandom_range(19);
      if (sel < 8)       in_a_bits_opcode = 3'd4;
      else if (sel < 12) in_a_bits_opcode = 3'd0;
      else if (sel < 15) in_a_bits_opcode = 3'd1;
      else               in_a_bits_opcode = 3'($urandom_range(7));
      in_a_bits_size    = 2'($urandom_range(3));
      in_a_bits_source  = 9'($urandom);
      in_a_bits_address = ($urandom_range(4) != 0) ? BASE + 26'($urandom_range(511)) : 26'($urandom);
      in_a_bits_mask    = 8'($urandom);
      in_a_bits_data    = {$urandom, $urandom};
      in_a_bits_corrupt = ($urandom_range(7) == 0);
      in_a_bits_param   = 3'($urandom);
      tick(acc);
    end
    in_a_valid = 1'b0;
    drain();
  endtask

  task automatic test_mid_reset();
    popped.delete();
    in_d_ready = 1'b0;
    send(3'd4, 2'd3, 9'h021, BASE + 26'h8, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 2'd3, 9'h022, BASE + 26'h10, 8'hFF, 64'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (in_d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_valid got=%b exp=0", in_d_valid);
    end
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
`ifdef TL_SCRATCH_PROTCHK_EN
    vectors++;
    if (prot_err !== 1'b0) begin
      miscompares++;
      $display("FAIL prot_err_clear got=%b exp=0", prot_err);
    end
`endif
    send(3'd4, 2'd3, 9'h023, BASE + 26'h8, 8'hFF, 64'd0, 1'b0);
    drain();
    vectors++;
    if (popped.size() != 1 || popped[0].source !== 9'h023 || popped[0].data !== 64'd0) begin
      miscompares++;
      $display("FAIL mid_reset_flush got n=%0d exp n=1 src=023 data=0", popped.size());
    end
  endtask

  initial begin
    reset             = 1'b1;
    in_a_valid        = 1'b0;
    in_a_bits_opcode  = 3'd0;
    in_a_bits_param   = 3'd0;
    in_a_bits_size    = 2'd0;
    in_a_bits_source  = 9'd0;
    in_a_bits_address = 26'd0;
    in_a_bits_mask    = 8'd0;
    in_a_bits_data    = 64'd0;
    in_a_bits_corrupt = 1'b0;
    in_d_ready        = 1'b0;
    test_reset();
    test_get_after_reset();
    test_put_get();
    test_partial();
    test_out_of_range();
    test_backpressure();
`ifdef TL_SCRATCH_PROTCHK_EN
    test_protchk();
`endif
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
